arbitro_mem_dados: RTL and testbench
====================================

// Module: arbitro_mem_dados
// PURPOSE
// - Arbitrates the single-port data memory between two requesters: port 0 (processor datapath) and port 1 (loader/debug).
// - Serialises accesses with a req/ack handshake, drives the memory port from registers, returns read data with a one-cycle ack.
// - Sits between the data-memory users and the data memory; the memory side is the only path to the memory.
// PARAMETERS
// - LARG_END   8   address width, both ports and memory
// - LARG_DADO  32  data width
// - LAT_LEIT   1   memory read latency in cycles after mem_en; legal range 1..7
// PORTS
// - clk            in   1          single clock, all state on rising edge
// - rst_n          in   1          reset, asynchronous, active-low
// - req0, req1     in   1          access request, held until ack
// - esc0, esc1     in   1          1 = write, 0 = read; sampled at grant
// - end0, end1     in   LARG_END   address; sampled at grant
// - dado_entr0/1   in   LARG_DADO  write data; sampled at grant
// - ack0, ack1     out  1          one-cycle completion pulse
// - dado_sai0/1    out  LARG_DADO  read data; valid in the ack cycle, held until the next read completes on that port
// - mem_en         out  1          memory access strobe, exactly one cycle per transaction
// - mem_esc        out  1          memory write enable; qualified by mem_en
// - mem_end        out  LARG_END   memory address (registered)
// - mem_dado_entr  out  LARG_DADO  memory write data (registered)
// - mem_dado_sai   in   LARG_DADO  memory read data
// - ocupado        out  1          1 in every state except OCIOSO
// BEHAVIOUR
// - Reset: state=OCIOSO; ack0/1, mem_en, mem_esc, ocupado=0; mem_end, mem_dado_entr, dado_sai0/1=0; ultimo=1.
// - Reset mid-transaction aborts it immediately: no ack, no mem_en; the memory write completes only if mem_en was already issued.
// - FSM OCIOSO -> ACESSO -> (write) CONCLUI | (read) ESPERA -> CONCLUI -> OCIOSO.
// - OCIOSO: if any req, latch winner id, esc, end, dado_entr -> ACESSO. Otherwise stay.
// - ACESSO: mem_en=1, mem_esc=latched esc. Write -> CONCLUI; read -> ESPERA with cnt=LAT_LEIT-1.
// - ESPERA: stays while cnt != 0, decrementing; when cnt==0, captures mem_dado_sai into winner's dado_sai -> CONCLUI.
// - CONCLUI: winner's ack=1 for exactly this cycle; ultimo<=winner -> OCIOSO.
// - Latency from the req-sampled cycle T0: write ack at T0+2; read ack at T0+2+LAT_LEIT.
// - Minimum spacing between two grants is one OCIOSO cycle after CONCLUI.
// - Requester deasserts req in the cycle after ack. req still high in OCIOSO is a new request.
// - req dropped before ack does not abort; the transaction completes and ack still pulses.
// - Inputs of the non-granted port are ignored. The granted port's end/dado may change after grant without effect.
// - Arbitration (default round-robin):
//   - only one req -> that port wins;
//   - both -> port != ultimo wins;
//   - ultimo=1 after reset, so port 0 wins the first tie.
// - Never more than one ack high; never ack without a preceding mem_en of the same transaction.
// CONFIGURATION
// - ARB_PRIORIDADE_FIXA_EN defined: port 0 always wins a tie. ultimo is still updated but ignored.
//   Port 1 is granted only in OCIOSO cycles where req0=0.
// - Not defined: round-robin as above.
// - Latency and handshake are identical in both builds.
// TESTING
// - rst_n=0 during ESPERA of a port-1 read -> ack1=0, mem_en=0, ocupado=0 at once.
//   After release with both req -> port 0 granted first.
// - req0, esc0=1, end0=0x10, dado_entr0=0xDEADBEEF alone at T0 -> T1: mem_en=1, mem_esc=1, mem_end=0x10; T2: ack0=1.
// - Then req1, esc1=0, end1=0x10 at T0 (LAT_LEIT=1) -> T1: mem_en=1, mem_esc=0; T3: ack1=1, dado_sai1=0xDEADBEEF.
// - req0, req1 held high continuously (reads), default build -> grants alternate 0,1,0,1. Each ack is 4 cycles apart.
// - Same stimulus with ARB_PRIORIDADE_FIXA_EN -> only ack0 pulses.
//   Drop req0 -> port 1 is granted in the next OCIOSO cycle.
// - LAT_LEIT=3, port-0 read of 0x05 at T0 -> mem_en at T1 only; ack0 and captured data at T5.

Source files
------------

// File: rtl/arbitro_mem_dados.sv
// Arbiter for the single-port data memory shared by the datapath (port 0) and the loader/debug port (port 1).
// Round-robin on ties by default; define ARB_PRIORIDADE_FIXA_EN to give port 0 fixed priority.
module arbitro_mem_dados #(
    parameter int unsigned LARG_END  = 8,
    parameter int unsigned LARG_DADO = 32,
    parameter int unsigned LAT_LEIT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 esc0,
    input  logic                 esc1,
    input  logic [LARG_END-1:0]  end0,
    input  logic [LARG_END-1:0]  end1,
    input  logic [LARG_DADO-1:0] dado_entr0,
    input  logic [LARG_DADO-1:0] dado_entr1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [LARG_DADO-1:0] dado_sai0,
    output logic [LARG_DADO-1:0] dado_sai1,
    output logic                 mem_en,
    output logic                 mem_esc,
    output logic [LARG_END-1:0]  mem_end,
    output logic [LARG_DADO-1:0] mem_dado_entr,
    input  logic [LARG_DADO-1:0] mem_dado_sai,
    output logic                 ocupado
);

    localparam int unsigned LARG_CNT = 3;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        ESPERA  = 2'd2,
        CONCLUI = 2'd3
    } estado_t;

    estado_t             estado;
    logic                vencedor;
    logic                ultimo;
    logic                esc_lat;
    logic [LARG_CNT-1:0] cnt;
    logic                venc_c;

    // Port chosen if a grant happens this cycle (0 or 1)
    always_comb begin
        venc_c = ~req0;
`ifdef ARB_PRIORIDADE_FIXA_EN
        if (req0 && req1) venc_c = 1'b0;
`else
        if (req0 && req1) venc_c = ~ultimo;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            vencedor      <= 1'b0;
            ultimo        <= 1'b1;
            esc_lat       <= 1'b0;
            cnt           <= '0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            dado_sai0     <= '0;
            dado_sai1     <= '0;
            mem_en        <= 1'b0;
            mem_esc       <= 1'b0;
            mem_end       <= '0;
            mem_dado_entr <= '0;
            ocupado       <= 1'b0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            mem_en  <= 1'b0;
            mem_esc <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (req0 || req1) begin
                        vencedor      <= venc_c;
                        esc_lat       <= venc_c ? esc1 : esc0;
                        mem_esc       <= venc_c ? esc1 : esc0;
                        mem_end       <= venc_c ? end1 : end0;
                        mem_dado_entr <= venc_c ? dado_entr1 : dado_entr0;
                        mem_en        <= 1'b1;
                        ocupado       <= 1'b1;
                        estado        <= ACESSO;
                    end
                end
                ACESSO: begin
                    if (esc_lat) begin
                        ack0   <= ~vencedor;
                        ack1   <= vencedor;
                        estado <= CONCLUI;
                    end else begin
                        cnt    <= LARG_CNT'(LAT_LEIT - 1);
                        estado <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LARG_CNT'(1);
                    end else begin
                        if (vencedor) dado_sai1 <= mem_dado_sai;
                        else          dado_sai0 <= mem_dado_sai;
                        ack0   <= ~vencedor;
                        ack1   <= vencedor;
                        estado <= CONCLUI;
                    end
                end
                CONCLUI: begin
                    ultimo  <= vencedor;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// Self-checking bench for arbitro_mem_dados: vector table plus directed reset/arbitration/latency sequences.
module tb_arbitro_mem_dados;

    localparam int unsigned LE = 8;
    localparam int unsigned LD = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0, req1, esc0, esc1;
    logic [LE-1:0] end0, end1;
    logic [LD-1:0] dado_entr0, dado_entr1;
    logic          ack0, ack1;
    logic [LD-1:0] dado_sai0, dado_sai1;
    logic          mem_en, mem_esc, ocupado;
    logic [LE-1:0] mem_end;
    logic [LD-1:0] mem_dado_entr, mem_dado_sai;

    logic          b_req0, b_req1, b_esc0, b_esc1;
    logic [LE-1:0] b_end0, b_end1;
    logic [LD-1:0] b_dado_entr0, b_dado_entr1;
    logic          b_ack0, b_ack1;
    logic [LD-1:0] b_dado_sai0, b_dado_sai1;
    logic          b_mem_en, b_mem_esc, b_ocupado;
    logic [LE-1:0] b_mem_end;
    logic [LD-1:0] b_mem_dado_entr, b_mem_dado_sai;

    arbitro_mem_dados #(.LARG_END(LE), .LARG_DADO(LD), .LAT_LEIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .esc0(esc0), .esc1(esc1),
        .end0(end0), .end1(end1), .dado_entr0(dado_entr0), .dado_entr1(dado_entr1),
        .ack0(ack0), .ack1(ack1), .dado_sai0(dado_sai0), .dado_sai1(dado_sai1),
        .mem_en(mem_en), .mem_esc(mem_esc), .mem_end(mem_end),
        .mem_dado_entr(mem_dado_entr), .mem_dado_sai(mem_dado_sai), .ocupado(ocupado)
    );

    arbitro_mem_dados #(.LARG_END(LE), .LARG_DADO(LD), .LAT_LEIT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(b_req1), .esc0(b_esc0), .esc1(b_esc1),
        .end0(b_end0), .end1(b_end1), .dado_entr0(b_dado_entr0), .dado_entr1(b_dado_entr1),
        .ack0(b_ack0), .ack1(b_ack1), .dado_sai0(b_dado_sai0), .dado_sai1(b_dado_sai1),
        .mem_en(b_mem_en), .mem_esc(b_mem_esc), .mem_end(b_mem_end),
        .mem_dado_entr(b_mem_dado_entr), .mem_dado_sai(b_mem_dado_sai), .ocupado(b_ocupado)
    );

    function automatic logic [LD-1:0] pat(int i);
        return {8'(i), 8'hC3, 8'(~i), 8'h5A};
    endfunction

    // Memory models: data only valid exactly LAT cycles after mem_en, garbage otherwise
    int            cyc = 0;
    logic [LD-1:0] mem_a [256];
    logic [LD-1:0] mem_b [256];
    logic [LD-1:0] ref_mem [256];
    logic [LD-1:0] pipe_a;
    logic [LD-1:0] pipe_b [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_esc) mem_a[mem_end] <= mem_dado_entr;
        pipe_a <= mem_en ? mem_a[mem_end] : (32'hBAD0_0000 | 32'(cyc));
        if (b_mem_en && b_mem_esc) mem_b[b_mem_end] <= b_mem_dado_entr;
        pipe_b[0] <= b_mem_en ? mem_b[b_mem_end] : (32'hBAD1_0000 | 32'(cyc));
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_dado_sai   = pipe_a;
    assign b_mem_dado_sai = pipe_b[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit            port;
        bit            esc;
        logic [LD-1:0] data;
    } exp_t;

    typedef struct {
        bit            port;
        bit            esc;
        logic [LE-1:0] addr;
        logic [LD-1:0] data;
        int            lat;
    } vec_t;

    exp_t sb[$];
    int   ack_times[$];
    int   men_cnt = 0;

    // Scoreboard: every ack pops the oldest expected transaction
    always @(negedge clk) begin
        if (!rst_n) begin
            men_cnt = 0;
        end else begin
            if (mem_en) men_cnt++;
            if (ack0 || ack1) begin
                exp_t e;
                check("ack_exclusive", 64'(ack0 & ack1), 64'd0);
                check("mem_en_per_txn", 64'(men_cnt), 64'd1);
                men_cnt = 0;
                ack_times.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 64'(ack1), 64'(e.port));
                    if (!e.esc) check("read_data", 64'(ack1 ? dado_sai1 : dado_sai0), 64'(e.data));
                end
            end
        end
    end

    task automatic expect_txn(input bit port, input bit esc, input logic [LE-1:0] a, input logic [LD-1:0] d);
        exp_t e;
        e.port = port;
        e.esc  = esc;
        e.data = esc ? d : ref_mem[a];
        if (esc) ref_mem[a] = d;
        sb.push_back(e);
    endtask

    // Drive one transaction from the OCIOSO negedge; returns with req dropped in the cycle after ack
    task automatic run_txn(input vec_t v);
        int k;
        bit got;
        expect_txn(v.port, v.esc, v.addr, v.data);
        if (!v.port) begin
            req0 = 1'b1; esc0 = v.esc; end0 = v.addr; dado_entr0 = v.data;
            esc1 = 1'($urandom); end1 = 8'($urandom); dado_entr1 = $urandom;
        end else begin
            req1 = 1'b1; esc1 = v.esc; end1 = v.addr; dado_entr1 = v.data;
            esc0 = 1'($urandom); end0 = 8'($urandom); dado_entr0 = $urandom;
        end
        @(negedge clk);
        k = 1;
        check("t1_mem_en", 64'(mem_en), 64'd1);
        check("t1_mem_esc", 64'(mem_esc), 64'(v.esc));
        check("t1_mem_end", 64'(mem_end), 64'(v.addr));
        if (v.esc) check("t1_mem_dado_entr", 64'(mem_dado_entr), 64'(v.data));
        // granted port's inputs change after grant: must not matter
        end0 = 8'($urandom); end1 = 8'($urandom);
        dado_entr0 = $urandom; dado_entr1 = $urandom;
        got = 1'b0;
        while (!got && k < 20) begin
            if (v.port ? ack1 : ack0) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("ack_latency", 64'(got ? k : 999), 64'(v.lat));
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int k;
        bit got;
        for (int i = 0; i < 256; i++) begin
            mem_a[i]   = pat(i);
            mem_b[i]   = pat(i);
            ref_mem[i] = pat(i);
        end
        vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 2};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0, 3};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 32'h12345678, 2};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 32'h0, 3};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 32'h0, 3};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 32'h0, 2};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 32'h0, 3};
        vecs[7] = '{1'b0, 1'b1, 8'h10, 32'hCAFEF00D, 2};
        vecs[8] = '{1'b1, 1'b0, 8'h10, 32'h0, 3};
        vecs[9] = '{1'b0, 1'b0, 8'h7F, 32'h0, 3};

        rst_n = 1'b0;
        req0 = 0; req1 = 0; esc0 = 0; esc1 = 0; end0 = '0; end1 = '0;
        dado_entr0 = '0; dado_entr1 = '0;
        b_req0 = 0; b_req1 = 0; b_esc0 = 0; b_esc1 = 0; b_end0 = '0; b_end1 = '0;
        b_dado_entr0 = '0; b_dado_entr1 = '0;
        repeat (3) @(negedge clk);

        check("rst_ack0", 64'(ack0), 64'd0);
        check("rst_ack1", 64'(ack1), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_esc", 64'(mem_esc), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_mem_end", 64'(mem_end), 64'd0);
        check("rst_mem_dado_entr", 64'(mem_dado_entr), 64'd0);
        check("rst_dado_sai0", 64'(dado_sai0), 64'd0);
        check("rst_dado_sai1", 64'(dado_sai1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ocupado", 64'(ocupado), 64'd0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);
        check("dado_sai1_held", 64'(dado_sai1), 64'hCAFEF00D);

        // Reset during ESPERA of a port-1 read aborts it at once
        req1 = 1'b1; esc1 = 1'b0; end1 = 8'h20;
        @(negedge clk);
        @(negedge clk);
        check("espera_ocupado", 64'(ocupado), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ack1", 64'(ack1), 64'd0);
        check("abort_mem_en", 64'(mem_en), 64'd0);
        check("abort_ocupado", 64'(ocupado), 64'd0);
        req0 = 1'b1; esc0 = 1'b0; end0 = 8'h30; end1 = 8'h31;
        ack_times.delete();
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_PRIORIDADE_FIXA_EN
            expect_txn(1'b0, 1'b0, 8'h30, '0);
`else
            expect_txn(1'(i % 2), 1'b0, (i % 2) ? 8'h31 : 8'h30, '0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && ack_times.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        check("tie_ack_count", 64'(ack_times.size()), 64'd4);
        for (int i = 1; i < 4 && i < ack_times.size(); i++)
            check("tie_ack_spacing", 64'(ack_times[i] - ack_times[i-1]), 64'd4);

        // Port 1 granted in the OCIOSO cycle right after req0 drops
        @(negedge clk);
        req0 = 1'b0;
        expect_txn(1'b1, 1'b0, 8'h31, '0);
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (ack1) got = 1'b1;
        end
        check("p1_after_drop_latency", 64'(got ? k : 999), 64'd3);
        @(negedge clk);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        // LAT_LEIT=3 instance: mem_en only at T1, ack and data at T5
        b_req0 = 1'b1; b_esc0 = 1'b0; b_end0 = 8'h05;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("lat3_mem_en", 64'(b_mem_en), 64'(i == 1));
            check("lat3_ack0", 64'(b_ack0), 64'(i == 5));
            if (i == 5) check("lat3_dado_sai0", 64'(b_dado_sai0), 64'(pat(5)));
        end
        @(negedge clk);
        b_req0 = 1'b0;
        repeat (2) @(negedge clk);
        check("lat3_ocupado_idle", 64'(b_ocupado), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
